// File: rtl/seg_scan4.sv
// Four-digit multiplexed 7-segment scan driver with hc4511-style decode,
// leading-zero blanking and an anti-ghost blanking gap at each slot start.
module seg_scan4 #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned LZB_EN    = 1
) (
  input  logic        CP,
  input  logic        MRN,
  input  logic        LE,
  input  logic [15:0] Dn,
  input  logic [3:0]  DP,
  input  logic        BI_N,
  input  logic        LT_N,
  output logic [7:0]  Seg,
  output logic [3:0]  Com,
  output logic        Frame
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   dig;
  logic [3:0]    dp_q;
  logic [7:0]    seg_nx;
  logic [3:0]    com_nx;
  logic          frame_nx;
  logic [3:0]    lzb;
  logic [3:0]    cur;
  logic          gap;

  // hc4511 a..g decode; codes 10-15 blank
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7C;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h67;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Leading-zero chain from digit 3 down; a set DP breaks the chain
  always_comb begin
    lzb    = 4'b0000;
    lzb[3] = (LZB_EN != 0) && (dig[15:12] == 4'd0) && !dp_q[3];
    lzb[2] = lzb[3] && (dig[11:8] == 4'd0) && !dp_q[2];
    lzb[1] = lzb[2] && (dig[7:4] == 4'd0) && !dp_q[1];
  end

  // Next slot counter/index and next registered outputs
  always_comb begin
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    seg_nx   = 8'h00;
    com_nx   = 4'b1111;
    frame_nx = (cnt == CW'(0)) && (idx == 2'd0);
    cur      = dig[{idx, 2'b00} +: 4];
    gap      = 32'(cnt) < BLANK_CYC;
    if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt_nx = CW'(0);
      idx_nx = idx + 2'd1;
    end
    if (!gap) begin
      com_nx = 4'(~(4'b0001 << idx));
      if (!LT_N)          seg_nx = 8'hFF;
      else if (!BI_N)     seg_nx = 8'h00;
      else if (lzb[idx])  seg_nx = 8'h00;
      else                seg_nx = {dp_q[idx], decode(cur)};
    end
  end

  // State, latch and output registers with synchronous reset
  always_ff @(posedge CP) begin
    if (!MRN) begin
      cnt   <= CW'(0);
      idx   <= 2'd0;
      dig   <= 16'h0000;
      dp_q  <= 4'b0000;
      Seg   <= 8'h00;
      Com   <= 4'b1111;
      Frame <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      Seg   <= seg_nx;
      Com   <= com_nx;
      Frame <= frame_nx;
      if (!LE) begin
        dig  <= Dn;
        dp_q <= DP;
      end
    end
  end

endmodule
